// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative multiply/divide unit with HI/LO result registers.
// MULTU/MULT use a radix-2 shift-add multiplier and DIVU/DIV use a restoring
// divider. Each takes WIDTH cycles and works on unsigned magnitudes, with the
// sign fixed up at write-back.
// Optional feature macro: MULT_DIV_DIV_EN compiles in the divider datapath and
// the DIV state. Without it, op 1x completes at once with HI/LO unchanged.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned ACC_W = 2 * WIDTH;
  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

`ifdef MULT_DIV_DIV_EN
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
`endif

  state_t state_q, state_d;

  // Shared accumulator: multiply {partial product, multiplier}; divide {remainder, quotient}
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] ma_q, ma_d;     // multiplicand magnitude
  logic             neg_q, neg_d;   // product / quotient must be negated
  logic             busy_d, done_d;
  logic [WIDTH-1:0] hi_d, lo_d;

`ifdef MULT_DIV_DIV_EN
  logic [WIDTH-1:0] mb_q, mb_d;            // divisor magnitude
  logic             rem_neg_q, rem_neg_d;  // remainder takes dividend sign
`endif

  // Operand magnitudes; only signed ops take the absolute value
  logic [WIDTH-1:0] mag_a, mag_b;
  always_comb begin
    mag_a = src_a;
    mag_b = src_b;
    if (op[0] && src_a[WIDTH-1]) mag_a = -src_a;
    if (op[0] && src_b[WIDTH-1]) mag_b = -src_b;
  end

  // One shift-add step: add multiplicand to upper half on multiplier LSB, shift right
  logic [WIDTH:0]   mul_sum;
  logic [ACC_W-1:0] mul_step, mul_res;
  always_comb begin
    mul_sum  = {1'b0, acc_q[ACC_W-1:WIDTH]} + {1'b0, {WIDTH{acc_q[0]}} & ma_q};
    mul_step = {mul_sum, acc_q[WIDTH-1:1]};
    mul_res  = neg_q ? -mul_step : mul_step;
  end

`ifdef MULT_DIV_DIV_EN
  // One restoring step: shift in next dividend bit, subtract divisor if it fits
  logic [WIDTH:0]   div_shift;
  logic             div_ok;
  logic [WIDTH-1:0] rem_step, quo_step, rem_res, quo_res;
  always_comb begin
    div_shift = {acc_q[ACC_W-1:WIDTH], acc_q[WIDTH-1]};
    div_ok    = (div_shift >= {1'b0, mb_q});
    rem_step  = div_ok ? WIDTH'(div_shift - {1'b0, mb_q}) : div_shift[WIDTH-1:0];
    quo_step  = {acc_q[WIDTH-2:0], div_ok};
    rem_res   = rem_neg_q ? -rem_step : rem_step;
    quo_res   = neg_q ? -quo_step : quo_step;
  end
`endif

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ma_d    = ma_q;
    neg_d   = neg_q;
    hi_d    = hi;
    lo_d    = lo;
    busy_d  = 1'b0;
    done_d  = 1'b0;
`ifdef MULT_DIV_DIV_EN
    mb_d      = mb_q;
    rem_neg_d = rem_neg_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          ma_d  = mag_a;
          neg_d = op[0] & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
          cnt_d = '0;
`ifdef MULT_DIV_DIV_EN
          mb_d      = mag_b;
          rem_neg_d = op[0] & src_a[WIDTH-1];
          if (op[1]) begin
            acc_d = {{WIDTH{1'b0}}, mag_a};
            // Divide by zero completes immediately with HI/LO untouched
            state_d = (src_b == '0) ? DONE : DIV;
          end else begin
            acc_d   = {{WIDTH{1'b0}}, mag_b};
            state_d = MUL;
          end
`else
          if (op[1]) begin
            state_d = DONE;
          end else begin
            acc_d   = {{WIDTH{1'b0}}, mag_b};
            state_d = MUL;
          end
`endif
        end else begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end

      MUL: begin
        acc_d = mul_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          {hi_d, lo_d} = mul_res;
          state_d      = DONE;
        end
      end

`ifdef MULT_DIV_DIV_EN
      DIV: begin
        acc_d = {rem_step, quo_step};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          hi_d    = rem_res;
          lo_d    = quo_res;
          state_d = DONE;
        end
      end
`endif

      DONE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

`ifdef MULT_DIV_DIV_EN
    busy_d = (state_d == MUL) || (state_d == DIV);
`else
    busy_d = (state_d == MUL);
`endif
    done_d = (state_d == DONE);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      ma_q      <= '0;
      neg_q     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      hi        <= '0;
      lo        <= '0;
`ifdef MULT_DIV_DIV_EN
      mb_q      <= '0;
      rem_neg_q <= 1'b0;
`endif
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ma_q      <= ma_d;
      neg_q     <= neg_d;
      busy      <= busy_d;
      done      <= done_d;
      hi        <= hi_d;
      lo        <= lo_d;
`ifdef MULT_DIV_DIV_EN
      mb_q      <= mb_d;
      rem_neg_q <= rem_neg_d;
`endif
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Testbench for mult_div_unit: directed literal cases plus a random phase,
// all checked every cycle against a transaction-level model of HI/LO/busy/done.
// Honours MULT_DIV_DIV_EN the same way the design does.
`timescale 1ns/1ps
module tb_mult_div_unit;

  localparam int unsigned W  = 32;
  localparam int unsigned W2 = 2 * W;
`ifdef MULT_DIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] src_a, src_b, wdata;
  logic         hi_we, lo_we;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .src_a (src_a),
    .src_b (src_b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Arithmetic reference: what HI/LO must become, or 'instant' for no-result ops
  function automatic void calc(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                               output bit instant, output logic [W-1:0] rh, output logic [W-1:0] rl);
    logic [W2-1:0] p;
    longint sa, sb, q, r;
    instant = 1'b0;
    rh = '0;
    rl = '0;
    sa = $signed(a);
    sb = $signed(b);
    case (o)
      2'b00: begin
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        {rh, rl} = p;
      end
      2'b01: begin
        p = W2'(sa * sb);
        {rh, rl} = p;
      end
      default: begin
        if (!DIV_EN || b == '0) begin
          instant = 1'b1;
        end else if (o == 2'b10) begin
          rl = a / b;
          rh = a % b;
        end else begin
          q  = sa / sb;
          r  = sa % sb;
          rl = W'(q);
          rh = W'(r);
        end
      end
    endcase
  endfunction

  // Transaction-level model: cycles left busy, done flag, architectural HI/LO
  int           m_left = 0;
  bit           m_done = 1'b0;
  bit           m_was_done;
  bit           m_inst;
  logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0, r_hi, r_lo;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0;
      m_done = 1'b0;
      m_hi   = '0;
      m_lo   = '0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_hi   = p_hi;
        m_lo   = p_lo;
        m_done = 1'b1;
      end
    end else begin
      m_was_done = m_done;
      m_done     = 1'b0;
      if (start && !m_was_done) begin
        calc(op, src_a, src_b, m_inst, r_hi, r_lo);
        if (m_inst) begin
          m_done = 1'b1;
        end else begin
          m_left = W;
          p_hi   = r_hi;
          p_lo   = r_lo;
        end
      end else begin
        if (hi_we) m_hi = wdata;
        if (lo_we) m_lo = wdata;
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    chk("busy", 64'(busy), 64'(m_left > 0));
    chk("done", 64'(done), 64'(m_done));
    chk("hi",   64'(hi),   64'(m_hi));
    chk("lo",   64'(lo),   64'(m_lo));
  end

  // Issue one op; report the cycle done appeared in and the busy-cycle count
  task automatic do_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int restart_k, input int we_k, output int done_k, output int busy_n);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    done_k = -1;
    busy_n = 0;
    for (int k = 1; k <= int'(W) + 8; k++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done) begin
        done_k = k;
        break;
      end
      #1;
      start = (k == restart_k);
      lo_we = (k == we_k);
      wdata = 32'hDEAD_BEEF;
      if (k == restart_k) begin
        op    = 2'b00;
        src_a = 32'h0000_0003;
        src_b = 32'h0000_0005;
      end
    end
    #1;
    start = 1'b0;
    lo_we = 1'b0;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: pick = '0;
      1: pick = 32'h0000_0001;
      2: pick = 32'hFFFF_FFFF;
      3: pick = 32'h8000_0000;
      4: pick = 32'h7FFF_FFFF;
      5: pick = 32'($urandom_range(0, 20));
      default: pick = $urandom;
    endcase
  endfunction

  int dk, bn;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    src_a = '0;
    src_b = '0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    wdata = '0;
    repeat (2) @(negedge clk);
    chk("reset_hi", 64'(hi), 64'h0);
    chk("reset_lo", 64'(lo), 64'h0);
    chk("reset_busy", 64'(busy), 64'h0);

    // MULTU max * max
    do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, dk, bn);
    chk("multu_done_cycle", 64'(dk), 64'd33);
    chk("multu_busy_cycles", 64'(bn), 64'd32);
    chk("multu_hi", 64'(hi), 64'hFFFF_FFFE);
    chk("multu_lo", 64'(lo), 64'h0000_0001);

    // MULT -3 * 7 with a stray start while busy
    do_op(2'b01, 32'hFFFF_FFFD, 32'h0000_0007, 5, 0, dk, bn);
    chk("mult_done_cycle", 64'(dk), 64'd33);
    chk("mult_hi", 64'(hi), 64'hFFFF_FFFF);
    chk("mult_lo", 64'(lo), 64'hFFFF_FFEB);

    // MTHI in IDLE
    @(negedge clk);
    #1;
    hi_we = 1'b1;
    wdata = 32'h1234_5678;
    @(negedge clk);
    chk("mthi_hi", 64'(hi), 64'h1234_5678);
    #1;
    hi_we = 1'b0;

    // lo_we during MUL must be ignored
    do_op(2'b00, 32'h0001_0000, 32'h0001_0001, 0, 10, dk, bn);
    chk("mtlo_busy_hi", 64'(hi), 64'h0000_0001);
    chk("mtlo_busy_lo", 64'(lo), 64'h0001_0000);

`ifdef MULT_DIV_DIV_EN
    do_op(2'b10, 32'd100, 32'd0, 0, 0, dk, bn);
    chk("divu0_done_cycle", 64'(dk), 64'd1);
    chk("divu0_hi", 64'(hi), 64'h0000_0001);
    chk("divu0_lo", 64'(lo), 64'h0001_0000);
    do_op(2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 0, 0, dk, bn);
    chk("div_done_cycle", 64'(dk), 64'd33);
    chk("div_lo", 64'(lo), 64'hFFFF_FFFD);
    chk("div_hi", 64'(hi), 64'hFFFF_FFFF);
    do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, dk, bn);
    chk("div_ovf_lo", 64'(lo), 64'h8000_0000);
    chk("div_ovf_hi", 64'(hi), 64'h0000_0000);
`else
    do_op(2'b11, 32'd10, 32'd3, 0, 0, dk, bn);
    chk("nodiv_done_cycle", 64'(dk), 64'd1);
    chk("nodiv_hi", 64'(hi), 64'h0000_0001);
    chk("nodiv_lo", 64'(lo), 64'h0001_0000);
`endif

    // Reset in cycle N+10 of a MULTU
    @(negedge clk);
    #1;
    start = 1'b1;
    op    = 2'b00;
    src_a = 32'hFFFF_0001;
    src_b = 32'h0000_FFFF;
    @(negedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_hi", 64'(hi), 64'h0);
    chk("midrst_lo", 64'(lo), 64'h0);
    chk("midrst_busy", 64'(busy), 64'h0);
    chk("midrst_done", 64'(done), 64'h0);
    repeat (2) @(negedge clk);
    // Release reset and start together
    do_op(2'b00, 32'd6, 32'd7, 0, 0, dk, bn);
    chk("post_rst_done_cycle", 64'(dk), 64'd33);
    chk("post_rst_lo", 64'(lo), 64'd42);
    chk("post_rst_hi", 64'(hi), 64'd0);

    // Random phase: starts and MTHI/MTLO at any state, occasional reset
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      #1;
      rst_n = ($urandom_range(0, 599) != 0);
      start = ($urandom_range(0, 5) == 0);
      op    = 2'($urandom_range(0, 3));
      src_a = pick();
      src_b = pick();
      hi_we = ($urandom_range(0, 7) == 0);
      lo_we = ($urandom_range(0, 7) == 0);
      wdata = $urandom;
    end
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    start = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    repeat (40) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
